seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for an 8-digit common-anode seven-segment display. It holds a 32-bit display word and steps a 3-bit nibble select through digits 0..7 at a programmable rate, inserting a dead-time gap between digits to suppress ghosting. Each nibble is decoded to segments. It sits between the CPU debug/IO register file and the board display pins. Display-word updates are frame-synchronous, so a digit sweep never shows a mix of old and new values.

## Interface
- TICK_DIV, 50000: clk cycles each digit is lit (≥2)
- BLANK_CYC, 16: dead-time cycles between digits, all anodes off (0 = no gap)
- CNT_W, 16: prescaler counter width; must hold max(TICK_DIV, BLANK_CYC)-1
- SEG_ACTIVE_LOW, 1: 1 = seg/dp driven low-active
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  scan enable; 0 forces IDLE
- load  in  1  one-cycle strobe: capture din/dp_in into shadow
- din  in  32  display word; nibble i → digit i (digit 7 = MS)
- dp_in  in  8  decimal point per digit, 1 = lit
- lz_en  in  1  leading-zero suppression enable
- sel  out  3  current digit index
- an  out  8  anode enables, active-low
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- frame_done  out  1  one-cycle pulse at end of digit 7 gap

## Operation
- FSM states: IDLE, SHOW, BLANK.
- IDLE:
  - an=8'hFF; segments off; sel=0; prescaler=0.
  - en=1 → SHOW.
- SHOW:
  - an[sel]=0; others 1.
  - Prescaler counts 0..TICK_DIV-1.
  - At terminal count → BLANK, or directly to the next digit in SHOW if BLANK_CYC=0.
- BLANK:
  - an=8'hFF.
  - Count 0..BLANK_CYC-1, then sel←sel+1 (7 wraps to 0) → SHOW.
- Wrap 7→0: frame_done=1 for one cycle. If pending is set, active←shadow and pending←0.
- load:
  - shadow←{dp_in,din}; pending←1.
  - load on the wrap cycle: active←{dp_in,din} directly; pending←0.
  - Back-to-back loads: the last one wins.
- en deasserted in any state → IDLE next cycle. sel and prescaler are cleared. active and shadow are kept.
- Leading-zero rule: with lz_en=1, digit i (i≥1) is blanked when nibbles 7..i of active are all 0. Blanking means segments off and dp from dp_in still honoured. Digit 0 is never blanked.
- Decode: hex 0–F, standard segment patterns. b and d are lower-case.
- SEG_ACTIVE_LOW inverts seg and dp.

## Timing
- Reset values:
  - an=8'hFF, seg=7'h7F, dp=1 (active-low off), sel=0, frame_done=0.
  - shadow=0, active=0, pending=0, state=IDLE.
- All outputs are registered. an/seg/dp change 1 cycle after the state/sel transition.
- Digit period = TICK_DIV+BLANK_CYC cycles. Frame = 8× that.
- Load to visible: the update appears at the next frame start, at most one frame + 1 cycle later.
- Reset mid-frame: outputs take reset values immediately (asynchronous) and pending load is lost.

## Structure
- Shared package: the FSM state enum, the 16-entry hex→segment constant table, and the anode-off constant 8'hFF.
- Sub-module: hex7seg, a combinational 4-bit → 7-segment decoder (active-high). Polarity inversion is done in the top level.
- Top level holds the FSM, prescaler, digit counter, shadow/active registers, LZ logic and nibble select.

## Test plan
Tests use TICK_DIV=4, BLANK_CYC=2, SEG_ACTIVE_LOW=1.
- Reset release, en=0 → an=FF, seg=7F, dp=1 held indefinitely.
- load din=32'h76543210, en=1 → after first frame, digit 0 shows seg=7'h40 for 4 cycles, then an=FF for 2 cycles. Digit 1 then shows seg=7'h79. frame_done pulses every 48 cycles.
- load 32'h00000088 mid-frame → old value persists until wrap. From the next frame, digits 0/1 show seg=7'h00.
- lz_en=1, active=32'h00000105 → an asserts for digits 0–2 only with segments lit. Digits 3–7 show segments off. With value 0, digit 0 shows 7'h40.
- en dropped during SHOW of digit 5 → IDLE next cycle, an=FF. On re-enable, scanning restarts at sel=0.
- load on the exact wrap cycle with din=32'hFFFFFFFF → active updates that frame and pending=0. Assert rst mid-BLANK → immediate reset values.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// FSM state encoding, hex-to-segment table and the all-anodes-off value.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Active-high {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7seg.sv
// Combinational 4-bit hex digit to active-high seven-segment pattern.
module hex7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex_to_seg(nib_i);

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit multiplexed seven-segment scan controller with dead-time gaps,
// frame-synchronous display updates and leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int BLANK_CYC      = 16,
  parameter int CNT_W          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        load_i,
  input  logic [31:0] din_i,
  input  logic [7:0]  dp_in_i,
  input  logic        lz_en_i,
  output logic [2:0]  sel_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        frame_done_o,
  output scan_state_e state_o
);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit               NO_GAP     = (BLANK_CYC == 0);
  localparam logic [6:0]       SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic             DP_OFF     = SEG_ACTIVE_LOW;

  scan_state_e      state_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic             frame_done_q;
  logic [39:0]      shadow_q;
  logic [39:0]      active_q;
  logic             pending_q;

  logic [7:0]  an_d;
  logic [6:0]  seg_d;
  logic        dp_d;
  logic [6:0]  seg_lit;
  logic        dp_lit;
  logic [6:0]  dec_seg;
  logic [3:0]  cur_nib;
  logic [7:0]  dp_word;
  logic [31:0] upper_nibs;
  logic        lz_blank;
  logic        show_last;
  logic        blank_last;
  logic        digit_end;
  logic        wrap;

  assign show_last  = (cnt_q == SHOW_LAST);
  assign blank_last = (cnt_q == BLANK_LAST);
  assign digit_end  = ((state_q == ST_SHOW) && show_last && NO_GAP) ||
                      ((state_q == ST_BLANK) && blank_last);
  assign wrap       = en_i && digit_end && (sel_q == 3'd7);

  // Digit i is suppressed when it and every more-significant nibble are zero.
  assign cur_nib    = active_q[{sel_q, 2'b00} +: 4];
  assign dp_word    = active_q[39:32];
  assign upper_nibs = active_q[31:0] >> {sel_q, 2'b00};
  assign lz_blank   = lz_en_i && (sel_q != 3'd0) && (upper_nibs == 32'd0);

  hex7seg u_hex7seg (
    .nib_i (cur_nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d    = ANODE_OFF;
    seg_lit = 7'h00;
    dp_lit  = 1'b0;
    if (state_q == ST_SHOW) begin
      an_d[sel_q] = 1'b0;
      seg_lit     = lz_blank ? 7'h00 : dec_seg;
      dp_lit      = dp_word[sel_q];
    end
    seg_d = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_d  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      sel_q        <= 3'd0;
      cnt_q        <= '0;
      an_q         <= ANODE_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
      if (!en_i) begin
        state_q <= ST_IDLE;
        sel_q   <= 3'd0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SHOW;
            cnt_q   <= '0;
          end
          ST_SHOW: begin
            if (show_last) begin
              cnt_q <= '0;
              if (NO_GAP) sel_q <= sel_q + 3'd1;
              else        state_q <= ST_BLANK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_BLANK: begin
            if (blank_last) begin
              cnt_q   <= '0;
              state_q <= ST_SHOW;
              sel_q   <= sel_q + 3'd1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // A load coinciding with the frame wrap bypasses the shadow entirely.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else if (wrap) begin
      if (load_i)         active_q <= {dp_in_i, din_i};
      else if (pending_q) active_q <= shadow_q;
      pending_q <= 1'b0;
    end else if (load_i) begin
      shadow_q  <= {dp_in_i, din_i};
      pending_q <= 1'b1;
    end
  end

  assign sel_o        = sel_q;
  assign an_o         = an_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign frame_done_o = frame_done_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame-position reference model feeds an expected
// queue that a negedge monitor drains, plus directed checks on key moments.
module tb_seg_scan_ctrl;
  import seg_scan_ctrl_pkg::*;

  localparam int TICK_DIV  = 4;
  localparam int BLANK_CYC = 2;
  localparam int DIGIT_P   = TICK_DIV + BLANK_CYC;
  localparam int FRAME_P   = 8 * DIGIT_P;
  localparam int W         = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] din;
  logic [7:0]  dp_in;
  logic        lz_en;
  logic [2:0]  sel;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;
  scan_state_e state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: position within the 48-cycle frame (-1 = idle).
  int          m_pos     = -1;
  logic [39:0] m_active  = '0;
  logic [39:0] m_shadow  = '0;
  bit          m_pending = 1'b0;

  seg_scan_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .BLANK_CYC      (BLANK_CYC),
    .CNT_W          (16),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .load_i       (load),
    .din_i        (din),
    .dp_in_i      (dp_in),
    .lz_en_i      (lz_en),
    .sel_o        (sel),
    .an_o         (an),
    .seg_o        (seg),
    .dp_o         (dp),
    .frame_done_o (frame_done),
    .state_o      (state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;
    logic [2:0] e_sel;
    int         d;
    if (rst) begin
      m_pos = -1; m_active = '0; m_shadow = '0; m_pending = 1'b0;
      exp_q.push_back({8'hFF, 7'h7F, 1'b1, 1'b0, 3'd0});
      return;
    end
    e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
    if (m_pos >= 0 && (m_pos % DIGIT_P) < TICK_DIV) begin
      d    = m_pos / DIGIT_P;
      e_an = ~(8'd1 << d);
      if (lz_en && d > 0 && (m_active[31:0] >> (4 * d)) == 32'd0) e_seg = 7'h7F;
      else e_seg = ~hex_seg(m_active[4*d +: 4]);
      e_dp = ~m_active[32 + d];
    end
    e_fd = en && (m_pos == FRAME_P - 1);
    if (e_fd) begin
      if (load) m_active = {dp_in, din};
      else if (m_pending) m_active = m_shadow;
      m_pending = 1'b0;
    end else if (load) begin
      m_shadow  = {dp_in, din};
      m_pending = 1'b1;
    end
    if (!en) m_pos = -1;
    else     m_pos = (m_pos + 1) % FRAME_P;
    e_sel = (m_pos < 0) ? 3'd0 : 3'(m_pos / DIGIT_P);
    exp_q.push_back({e_an, e_seg, e_dp, e_fd, e_sel});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {an, seg, dp, frame_done, sel};
        n_tests++;
        if (got_v !== exp_v) begin
          n_fail++;
          $display("FAIL scan_out @%0t: got an=%h seg=%h dp=%b fd=%b sel=%0d, required an=%h seg=%h dp=%b fd=%b sel=%0d",
                   $time, got_v[19:12], got_v[11:5], got_v[4], got_v[3], got_v[2:0],
                   exp_v[19:12], exp_v[11:5], exp_v[4], exp_v[3], exp_v[2:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, required %h", name, $time, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] w, input logic [7:0] p);
    @(negedge clk);
    din = w; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fd(input string name);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (frame_done !== 1'b1 && c < 3 * FRAME_P);
    n_tests++;
    if (frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: no frame_done within %0d cycles", name, c);
    end
  endtask

  task automatic wait_pos(input int p);
    int c = 0;
    while (m_pos != p && c < 4 * FRAME_P) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (m_pos != p) begin
      n_fail++;
      $display("FAIL wait_pos: position %0d not reached, at %0d", p, m_pos);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [31:0] w;
    rst = 1'b1; en = 1'b0; load = 1'b0; lz_en = 1'b0; din = '0; dp_in = '0;
    tick(3);
    rst = 1'b0;
    tick(10);
    check("idle_an", 32'(an), 32'hFF);
    check("idle_seg", 32'(seg), 32'h7F);
    check("idle_dp", 32'(dp), 32'h1);
    check("idle_state", 32'(state), 32'(ST_IDLE));

    do_load(32'h76543210, 8'h00);
    en = 1'b1;
    wait_fd("fd_first");
    tick(1);
    check("d0_seg", 32'(seg), 32'h40);
    check("d0_an", 32'(an), 32'hFE);
    tick(3);
    check("d0_hold", 32'(seg), 32'h40);
    tick(1);
    check("gap_an", 32'(an), 32'hFF);
    tick(2);
    check("d1_seg", 32'(seg), 32'h79);
    check("d1_an", 32'(an), 32'hFD);
    wait_fd("fd_second");
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (frame_done !== 1'b1 && c < 100);
    check("fd_period", 32'(c), 32'(FRAME_P));

    tick(20);
    do_load(32'h00000088, 8'h00);
    wait_fd("fd_88");
    tick(1);
    check("d88_d0", 32'(seg), 32'h00);

    lz_en = 1'b1;
    do_load(32'h00000105, 8'h00);
    wait_fd("fd_105");
    tick(13);
    check("lz_d2_seg", 32'(seg), 32'h79);
    tick(6);
    check("lz_d3_seg", 32'(seg), 32'h7F);
    do_load(32'h00000000, 8'h00);
    wait_fd("fd_zero");
    tick(1);
    check("lz_zero_d0", 32'(seg), 32'h40);

    for (int i = 0; i < 25; i++) begin
      tick($urandom_range(0, 40));
      w = $urandom() >> (4 * $urandom_range(0, 7));
      lz_en = 1'($urandom_range(0, 1));
      do_load(w, 8'($urandom()));
      if ($urandom_range(0, 5) == 0) begin
        en = 1'b0;
        tick($urandom_range(1, 8));
        en = 1'b1;
      end
    end
    lz_en = 1'b0;

    wait_pos(5 * DIGIT_P + 1);
    en = 1'b0;
    tick(1);
    check("drop_state", 32'(state), 32'(ST_IDLE));
    check("drop_sel", 32'(sel), 32'h0);
    tick(1);
    check("drop_an", 32'(an), 32'hFF);
    tick(3);
    en = 1'b1;
    tick(2);
    check("reen_an", 32'(an), 32'hFE);

    do_load(32'h00001234, 8'h00);
    wait_pos(FRAME_P - 1);
    din = 32'hFFFFFFFF; dp_in = 8'hFF; load = 1'b1;
    tick(1);
    load = 1'b0;
    check("wrap_fd", 32'(frame_done), 32'h1);
    tick(1);
    check("wrap_d0_seg", 32'(seg), 32'h0E);
    check("wrap_d0_dp", 32'(dp), 32'h0);
    wait_fd("fd_after_wrap_load");
    tick(1);
    check("wrap_pending_clear", 32'(seg), 32'h0E);

    do_load(32'hABCD0000, 8'h0F);
    wait_pos(DIGIT_P + TICK_DIV);
    #2 rst = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    tick(2);
    rst = 1'b0;
    wait_fd("fd_after_rst");
    tick(1);
    check("rst_pending_lost", 32'(seg), 32'h40);
    tick(FRAME_P);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
